// File: rtl/snake_step_scheduler.sv
// snake_step_scheduler
//   Game sequencer for the snake design. It owns the START/PLAY/END game
//   state and issues one move step per game tick over a Step_req/Step_ack
//   handshake. After each step it evaluates the collision and eat flags. It
//   then requests a new apple, ends the game with a blink phase, or keeps
//   ticking. The tick period shortens as the level rises.
//
//   Optional feature macro: SNAKE_PAUSE_EN (adds Key_pause, a pause toggle
//   that is honoured only while ticking).
//
// Ports:
//   Clk_50mhz     in   system clock
//   Rst           in   synchronous active-high reset
//   Key_start     in   one-cycle start/restart pulse
//   Key_pause     in   one-cycle pause toggle pulse (SNAKE_PAUSE_EN only)
//   Step_req      out  request one snake move
//   Step_ack      in   move done, collision/eat flags valid this cycle
//   Hit_wall_sig  in   wall collision, sampled with Step_ack
//   Hit_body_sig  in   self collision, sampled with Step_ack
//   Body_add_sig  in   apple eaten, sampled with Step_ack
//   Apple_req     out  request a new apple position
//   Apple_ack     in   apple generator done
//   Game_status   out  one-hot START=001 / PLAY=010 / END=100
//   Flash_sig     out  END-phase blink (also the pause blink)
//   Score         out  apples eaten, saturating at 255
//   Level         out  speed level 0..MAX_LEVEL
module snake_step_scheduler #(
  parameter int unsigned BASE_PERIOD      = 12500000,
  parameter int unsigned PERIOD_DEC       = 1250000,
  parameter int unsigned MIN_PERIOD       = 2500000,
  parameter int unsigned APPLES_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL        = 8,
  parameter int unsigned FLASH_HALF       = 12500000,
  parameter int unsigned FLASH_TOGGLES    = 6
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       Key_start,
`ifdef SNAKE_PAUSE_EN
  input  logic       Key_pause,
`endif
  output logic       Step_req,
  input  logic       Step_ack,
  input  logic       Hit_wall_sig,
  input  logic       Hit_body_sig,
  input  logic       Body_add_sig,
  output logic       Apple_req,
  input  logic       Apple_ack,
  output logic [2:0] Game_status,
  output logic       Flash_sig,
  output logic [7:0] Score,
  output logic [3:0] Level
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_TICK  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_APPLE = 3'd3;
  localparam logic [2:0] S_FLASH = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  localparam logic [23:0] FLASH_LAST = 24'(FLASH_HALF - 1);
  localparam logic [7:0]  TOG_LAST   = 8'(FLASH_TOGGLES - 1);
  localparam logic [7:0]  APPLE_LAST = 8'(APPLES_PER_LEVEL - 1);
  localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);

  // Clamped step period for a given level; written so the subtraction
  // never underflows.
  function automatic logic [23:0] period_of(input logic [3:0] lvl);
    int unsigned dec;
    dec = 32'(lvl) * PERIOD_DEC;
    if (dec + MIN_PERIOD >= BASE_PERIOD) return 24'(MIN_PERIOD);
    return 24'(BASE_PERIOD - dec);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] period_q;
  logic [7:0]  score_q, score_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  apples_q, apples_d;   // apples eaten since the last level-up
  logic [7:0]  tog_q, tog_d;
  logic        flash_q, flash_d;
  logic        step_req_q, apple_req_q;
  logic [2:0]  status_q, status_d;
  logic        tick_en;

`ifdef SNAKE_PAUSE_EN
  logic        paused_q, paused_d;
  logic [23:0] pcnt_q, pcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    level_d  = level_q;
    apples_d = apples_q;
    tog_d    = tog_q;
    flash_d  = flash_q;
    tick_en  = 1'b1;
`ifdef SNAKE_PAUSE_EN
    paused_d = paused_q;
    pcnt_d   = pcnt_q;
`endif
    case (state_q)
      S_START: begin
`ifdef SNAKE_PAUSE_EN
        paused_d = 1'b0;
        pcnt_d   = '0;
`endif
        if (Key_start) begin
          state_d  = S_TICK;
          score_d  = '0;
          level_d  = '0;
          apples_d = '0;
          cnt_d    = '0;
        end
      end
      S_TICK: begin
`ifdef SNAKE_PAUSE_EN
        // The toggle cycle itself still follows the old flag, so the
        // counter stops on the cycle after the pause pulse.
        tick_en = !paused_q;
        if (Key_pause) begin
          paused_d = !paused_q;
          pcnt_d   = '0;
          flash_d  = 1'b0;
        end else if (paused_q) begin
          if (pcnt_q == FLASH_LAST) begin
            pcnt_d  = '0;
            flash_d = !flash_q;
          end else begin
            pcnt_d = pcnt_q + 24'd1;
          end
        end
`endif
        if (tick_en) begin
          if (cnt_q == period_q - 24'd1) begin
            cnt_d   = '0;
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      S_STEP: begin
        if (Step_ack) begin
          if (Hit_wall_sig || Hit_body_sig) begin
            state_d = S_FLASH;
            cnt_d   = '0;
            tog_d   = '0;
            flash_d = 1'b0;
          end else if (Body_add_sig) begin
            state_d = S_APPLE;
            // Level advances only on a real score increment, so a
            // saturated score cannot keep bumping the level.
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
              if (apples_q == APPLE_LAST) begin
                apples_d = '0;
                if (level_q < LEVEL_MAX) level_d = level_q + 4'd1;
              end else begin
                apples_d = apples_q + 8'd1;
              end
            end
          end else begin
            state_d = S_TICK;
          end
        end
      end
      S_APPLE: begin
        if (Apple_ack) state_d = S_TICK;
      end
      S_FLASH: begin
        if (cnt_q == FLASH_LAST) begin
          cnt_d   = '0;
          flash_d = !flash_q;
          tog_d   = tog_q + 8'd1;
          if (tog_q == TOG_LAST) begin
            state_d = S_END;
            flash_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_END: begin
        flash_d = 1'b0;
        if (Key_start) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    status_d = 3'b010;
    case (state_d)
      S_START:        status_d = 3'b001;
      S_FLASH, S_END: status_d = 3'b100;
      default:        status_d = 3'b010;
    endcase
  end

  // Handshake requests and status are registered from the next state so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      state_q     <= S_START;
      cnt_q       <= '0;
      period_q    <= period_of(4'd0);
      score_q     <= '0;
      level_q     <= '0;
      apples_q    <= '0;
      tog_q       <= '0;
      flash_q     <= 1'b0;
      step_req_q  <= 1'b0;
      apple_req_q <= 1'b0;
      status_q    <= 3'b001;
`ifdef SNAKE_PAUSE_EN
      paused_q    <= 1'b0;
      pcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_of(level_d);
      score_q     <= score_d;
      level_q     <= level_d;
      apples_q    <= apples_d;
      tog_q       <= tog_d;
      flash_q     <= flash_d;
      step_req_q  <= (state_d == S_STEP);
      apple_req_q <= (state_d == S_APPLE);
      status_q    <= status_d;
`ifdef SNAKE_PAUSE_EN
      paused_q    <= paused_d;
      pcnt_q      <= pcnt_d;
`endif
    end
  end

  assign Step_req    = step_req_q;
  assign Apple_req   = apple_req_q;
  assign Game_status = status_q;
  assign Flash_sig   = flash_q;
  assign Score       = score_q;
  assign Level       = level_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler with small timing parameters. A hand-written
// vector table covers the opening game. Randomized play is then checked
// against a step-level reference model of score, level and tick period.
module tb_snake_step_scheduler;

  localparam int unsigned BASE = 20;
  localparam int unsigned DEC  = 4;
  localparam int unsigned MINP = 8;
  localparam int unsigned APL  = 2;
  localparam int unsigned MAXL = 8;
  localparam int unsigned FH   = 3;
  localparam int unsigned FT   = 4;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Key_start = 1'b0;
`ifdef SNAKE_PAUSE_EN
  logic       Key_pause = 1'b0;
`endif
  logic       Step_req;
  logic       Step_ack = 1'b0;
  logic       Hit_wall_sig = 1'b0;
  logic       Hit_body_sig = 1'b0;
  logic       Body_add_sig = 1'b0;
  logic       Apple_req;
  logic       Apple_ack = 1'b0;
  logic [2:0] Game_status;
  logic       Flash_sig;
  logic [7:0] Score;
  logic [3:0] Level;

  snake_step_scheduler #(
    .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP),
    .APPLES_PER_LEVEL(APL), .MAX_LEVEL(MAXL),
    .FLASH_HALF(FH), .FLASH_TOGGLES(FT)
  ) dut (
    .Clk_50mhz(clk), .Rst(Rst), .Key_start(Key_start),
`ifdef SNAKE_PAUSE_EN
    .Key_pause(Key_pause),
`endif
    .Step_req(Step_req), .Step_ack(Step_ack),
    .Hit_wall_sig(Hit_wall_sig), .Hit_body_sig(Hit_body_sig),
    .Body_add_sig(Body_add_sig), .Apple_req(Apple_req), .Apple_ack(Apple_ack),
    .Game_status(Game_status), .Flash_sig(Flash_sig),
    .Score(Score), .Level(Level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_level = 0;

  typedef struct {
    int ack_dly; bit wall; bit body; bit add; int apple_dly;
    int exp_int; int exp_score; int exp_level; int exp_status;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; every cycle
  // the status must be one-hot and the two requests must be exclusive.
  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot_excl", {30'd0, Step_req & Apple_req, $onehot(Game_status)}, 32'd1);
  endtask

  function automatic int exp_period(input int lvl);
    int p;
    p = int'(BASE) - lvl * int'(DEC);
    return (p < int'(MINP)) ? int'(MINP) : p;
  endfunction

  function automatic int exp_flash(input int k);
    int t;
    t = k / int'(FH);
    if (t > int'(FT)) t = int'(FT);
    return t % 2;
  endfunction

  // Called right after the edge that entered PLAY ticking. A stray ack with
  // collision/eat flags is offered first; it must be ignored.
  task automatic wait_step(input string tag, input int exp_int);
    int n;
    Step_ack = 1'b1; Hit_wall_sig = 1'b1; Body_add_sig = 1'b1;
    tick();
    Step_ack = 1'b0; Hit_wall_sig = 1'b0; Body_add_sig = 1'b0;
    n = 1;
    while (!Step_req && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_interval"}, n, exp_int);
  endtask

  task automatic do_step(input int ack_dly, input bit wall, input bit body,
                         input bit add, input int apple_dly);
    for (int i = 0; i < ack_dly; i++) begin
      Key_start = (i == 0);
      tick();
      Key_start = 1'b0;
      check("step_hold", Step_req, 1);
    end
    Step_ack = 1'b1; Hit_wall_sig = wall; Hit_body_sig = body; Body_add_sig = add;
    tick();
    Step_ack = 1'b0; Hit_wall_sig = 1'b0; Hit_body_sig = 1'b0; Body_add_sig = 1'b0;
    check("step_drop", Step_req, 0);
    if (!(wall || body) && add) begin
      if (m_score < 255) begin
        m_score++;
        if ((m_score % int'(APL)) == 0 && m_level < int'(MAXL)) m_level++;
      end
      check("apple_req", Apple_req, 1);
      for (int i = 0; i < apple_dly; i++) begin
        tick();
        check("apple_hold", Apple_req, 1);
      end
      Apple_ack = 1'b1;
      tick();
      Apple_ack = 1'b0;
      check("apple_drop", Apple_req, 0);
    end
  endtask

  task automatic start_game();
    Key_start = 1'b1;
    tick();
    Key_start = 1'b0;
    m_score = 0;
    m_level = 0;
    check("start_status", Game_status, 3'b010);
  endtask

  initial begin
    vecs[0] = '{5, 1'b0, 1'b0, 1'b1, 3, 20, 1, 0, 2};
    vecs[1] = '{2, 1'b0, 1'b0, 1'b1, 3, 20, 2, 1, 2};
    vecs[2] = '{1, 1'b0, 1'b0, 1'b0, 0, 16, 2, 1, 2};
    vecs[3] = '{0, 1'b0, 1'b0, 1'b1, 0, 16, 3, 1, 2};
    vecs[4] = '{3, 1'b0, 1'b1, 1'b1, 0, 16, 3, 1, 4};

    // Reset state
    tick(); tick();
    Rst = 1'b0;
    check("rst_status", Game_status, 3'b001);
    check("rst_step", Step_req, 0);
    check("rst_apple", Apple_req, 0);
    check("rst_flash", Flash_sig, 0);
    check("rst_score", Score, 0);
    check("rst_level", Level, 0);

    // Opening game from the table
    start_game();
    for (int i = 0; i < 5; i++) begin
      wait_step($sformatf("vec%0d", i), vecs[i].exp_int);
      do_step(vecs[i].ack_dly, vecs[i].wall, vecs[i].body, vecs[i].add, vecs[i].apple_dly);
      check($sformatf("vec%0d_score", i), Score, vecs[i].exp_score);
      check($sformatf("vec%0d_level", i), Level, vecs[i].exp_level);
      check($sformatf("vec%0d_status", i), Game_status, vecs[i].exp_status);
    end

    // Blink phase: k counts edges since entry; Key_start here is ignored
    for (int k = 0; k <= 20; k++) begin
      check($sformatf("flash_k%0d", k), Flash_sig, exp_flash(k));
      Key_start = (k == 2);
      tick();
      Key_start = 1'b0;
    end
    check("end_status", Game_status, 3'b100);
    check("end_score", Score, 3);
    check("end_level", Level, 1);
    check("end_flash", Flash_sig, 0);

    Key_start = 1'b1;
    tick();
    Key_start = 1'b0;
    check("restart_status", Game_status, 3'b001);
    start_game();
    check("restart_score", Score, 0);
    check("restart_level", Level, 0);

    // Randomized play against the model
    for (int i = 0; i < 40; i++) begin
      bit add;
      add = ($urandom_range(0, 9) < 7);
      wait_step("rnd", exp_period(m_level));
      do_step($urandom_range(0, 4), 1'b0, 1'b0, add, $urandom_range(0, 4));
      check("rnd_score", Score, m_score);
      check("rnd_level", Level, m_level);
      check("rnd_status", Game_status, 3'b010);
    end

    // Eat up to the top level; the period must clamp
    for (int g = 0; g < 60 && m_level < int'(MAXL); g++) begin
      wait_step("lvl", exp_period(m_level));
      do_step(1, 1'b0, 1'b0, 1'b1, 1);
    end
    check("lvl_max", Level, MAXL);
    wait_step("clamp", int'(MINP));
    do_step(0, 1'b0, 1'b0, 1'b0, 0);

    // Score saturation
    for (int g = 0; g < 400 && m_score < 255; g++) begin
      wait_step("sat", exp_period(m_level));
      do_step(0, 1'b0, 1'b0, 1'b1, 0);
    end
    wait_step("sat_last", int'(MINP));
    do_step(0, 1'b0, 1'b0, 1'b1, 0);
    check("sat_score", Score, 255);
    check("sat_model", m_score, 255);
    check("sat_level", Level, MAXL);

    // Wall collision ends the game with score held
    wait_step("wall", int'(MINP));
    do_step(2, 1'b1, 1'b0, 1'b0, 0);
    check("wall_status", Game_status, 3'b100);
    check("wall_score", Score, 255);
    for (int k = 1; k <= 14; k++) tick();
    check("wall_end_flash", Flash_sig, 0);
    Key_start = 1'b1;
    tick();
    Key_start = 1'b0;
    start_game();

    // Reset in the middle of a step handshake
    wait_step("rst_mid", int'(BASE));
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rstmid_step", Step_req, 0);
    check("rstmid_apple", Apple_req, 0);
    check("rstmid_status", Game_status, 3'b001);
    check("rstmid_flash", Flash_sig, 0);
    check("rstmid_score", Score, 0);
    check("rstmid_level", Level, 0);

`ifdef SNAKE_PAUSE_EN
    begin
      int toggles;
      int n;
      bit stepped;
      logic prev;
      start_game();
      Key_pause = 1'b1;
      tick();
      Key_pause = 1'b0;
      toggles = 0;
      stepped = 1'b0;
      prev = Flash_sig;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (Step_req) stepped = 1'b1;
        if (Flash_sig !== prev) toggles++;
        prev = Flash_sig;
      end
      check("pause_no_step", stepped, 0);
      check("pause_blink", (toggles >= 12 && toggles <= 14), 1);
      Key_pause = 1'b1;
      tick();
      Key_pause = 1'b0;
      check("unpause_flash", Flash_sig, 0);
      n = 1;
      while (!Step_req && n < 100) begin
        tick();
        n++;
      end
      check("unpause_step", (n >= 17 && n <= 20), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_step_scheduler.md
Name: snake_step_scheduler

Overview:
- Game sequencer for the snake design. Owns the START/PLAY/END game state and issues one move step per game tick to the snake datapath over a req/ack handshake.
- After each step it evaluates the collision and apple-eaten results. It then either requests a new apple from the apple generator or ends the game.
- Tick period shortens as score rises. Drives Game_status, Flash_sig and the score/level seen by the display blocks.

Parameters:
BASE_PERIOD, 12500000, clock cycles per step at level 0 (4 steps/s at 50 MHz)
PERIOD_DEC, 1250000, cycles removed from the period per level
MIN_PERIOD, 2500000, floor on the step period
APPLES_PER_LEVEL, 4, apples eaten per level increment
MAX_LEVEL, 8, level saturation value
FLASH_HALF, 12500000, cycles per Flash_sig half-period in END
FLASH_TOGGLES, 6, Flash_sig toggles before END settles

Ports:
Clk_50mhz  in  1  system clock
Rst  in  1  synchronous active-high reset
Key_start  in  1  one-cycle debounced start/restart pulse
Step_req  out  1  request one snake move
Step_ack  in  1  datapath move done; collision/eat flags valid this cycle
Hit_wall_sig  in  1  wall collision, sampled with Step_ack
Hit_body_sig  in  1  self collision, sampled with Step_ack
Body_add_sig  in  1  apple eaten, sampled with Step_ack
Apple_req  out  1  request new apple position
Apple_ack  in  1  apple generator done
Game_status  out  3  one-hot: START=001, PLAY=010, END=100
Flash_sig  out  1  END-state blink
Score  out  8  apples eaten, saturating at 255
Level  out  4  speed level 0..MAX_LEVEL

Behaviour:
- Interface: one clock (Clk_50mhz); reset Rst is synchronous and active-high.
- Reset values:
  - Game_status=001; Step_req=0; Apple_req=0; Flash_sig=0; Score=0; Level=0.
  - Tick counter=0; FSM in S_START.
- FSM states: S_START, S_TICK, S_STEP, S_APPLE, S_FLASH, S_END.
- S_START (status 001): Key_start=1 → S_TICK; clear Score, Level and tick counter.
- S_TICK (status 010):
  - Counter increments each cycle.
  - When counter = period-1: clear counter, go to S_STEP, assert Step_req next cycle.
  - period = max(BASE_PERIOD − Level·PERIOD_DEC, MIN_PERIOD), registered on every Level change. The counter is 24 bits.
- S_STEP:
  - Step_req held high until Step_ack=1.
  - Step_req drops the cycle after ack.
  - No timeout; ack while Step_req=0 is ignored.
- Ack evaluation, in priority order:
  1. Hit_wall_sig or Hit_body_sig → S_FLASH. Score unchanged; any eat in the same cycle is ignored.
  2. Body_add_sig → Score+1 (saturating), then S_APPLE.
  3. Otherwise → S_TICK.
- S_APPLE:
  - Apple_req held until Apple_ack; then S_TICK.
  - Level increments (saturating at MAX_LEVEL) when the new Score is a multiple of APPLES_PER_LEVEL.
  - The tick counter stays frozen during S_APPLE.
- S_FLASH (status 100):
  - Flash_sig toggles every FLASH_HALF cycles.
  - After FLASH_TOGGLES toggles → S_END with Flash_sig=0.
  - Key_start is ignored here.
- S_END (status 100): Flash_sig=0; Score and Level held. Key_start → S_START.
- Game_status is registered, one-hot, and never 000.
- Key_start in S_TICK/S_STEP/S_APPLE is ignored.
- Rst asserted mid-handshake drops Step_req/Apple_req on the next edge; no ack is awaited.
- Step_req and Apple_req are never high together.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- Defined:
  - Adds input Key_pause (1-bit pulse).
  - In S_TICK, Key_pause toggles a paused flag. While paused, the counter freezes and Flash_sig follows a FLASH_HALF blink.
  - Key_pause in other states is ignored.
  - The flag clears on reset and on entry to S_START.
- Undefined: no port; behaviour as above with no pause.

Test Plan (sim overrides: BASE_PERIOD=20, PERIOD_DEC=4, MIN_PERIOD=8, APPLES_PER_LEVEL=2, FLASH_HALF=3, FLASH_TOGGLES=4):
- Reset, then Key_start pulse → Game_status 001→010 next edge. First Step_req rises 20 cycles after PLAY entry and holds until Step_ack is given 5 cycles later.
- Ack with Body_add_sig=1 twice, Apple_ack after 3 cycles each time → Score=2, Level=1. Next step interval is 16 cycles; Apple_req is never high together with Step_req.
- Ack with Hit_body_sig=1 and Body_add_sig=1 together → Score unchanged, status 100. Flash_sig toggles 4 times at 3-cycle spacing, then stays 0.
- In S_END, Key_start → status 001; next Key_start → Score=0, Level=0, first step after 20 cycles.
- Sustain eating to Level 8 → step period clamps at 8 cycles. Score saturates at 255 when forced.
- Rst asserted while Step_req=1 → all outputs at reset values on the next edge. With SNAKE_PAUSE_EN, Key_pause in S_TICK freezes Step_req generation until a second Key_pause.
